// File: rtl/divide.sv
// Iterative restoring divider for MIPS DIV/DIVU.
// One quotient bit per cycle on magnitudes; sign applied when the last bit lands.
module divide #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              div_begin,
  input  logic              div_signed,
  input  logic [DATA_W-1:0] div_op1,
  input  logic [DATA_W-1:0] div_op2,
  output logic              div_busy,
  output logic              div_end,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] dvd_q, dvd_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [DATA_W-1:0] raw_q, raw_d;
  logic [DATA_W:0]   r_q, r_d;
  logic [DATA_W-1:0] qb_q, qb_d;
  logic              qs_q, qs_d;
  logic              rs_q, rs_d;
  logic              dz_q, dz_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] rem_q, rem_d;

  logic [DATA_W:0]   r_sh;
  logic [DATA_W:0]   r_nx;
  logic [DATA_W:0]   dvs_x;
  logic              ge;
  logic [DATA_W-1:0] q_nx;

  // One restoring step: shift in next dividend bit, subtract if it fits.
  always_comb begin
    dvs_x = {1'b0, dvs_q};
    r_sh  = (r_q << 1) | {{DATA_W{1'b0}}, dvd_q[DATA_W-1]};
    ge    = (r_sh >= dvs_x);
    r_nx  = ge ? (r_sh - dvs_x) : r_sh;
    q_nx  = (qb_q << 1) | {{(DATA_W-1){1'b0}}, ge};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    raw_d   = raw_q;
    r_d     = r_q;
    qb_d    = qb_q;
    qs_d    = qs_q;
    rs_d    = rs_q;
    dz_d    = dz_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (div_begin) begin
          dvd_d = (div_signed && div_op1[DATA_W-1]) ? -div_op1 : div_op1;
          dvs_d = (div_signed && div_op2[DATA_W-1]) ? -div_op2 : div_op2;
          raw_d = div_op1;
          qs_d  = div_signed & (div_op1[DATA_W-1] ^ div_op2[DATA_W-1]);
          rs_d  = div_signed & div_op1[DATA_W-1];
          dz_d  = (div_op2 == '0);
          r_d   = '0;
          qb_d  = '0;
          cnt_d = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        dvd_d = dvd_q << 1;
        r_d   = r_nx;
        qb_d  = q_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          if (dz_q) begin
            quo_d = '1;
            rem_d = raw_q;
          end else begin
            quo_d = qs_q ? -q_nx : q_nx;
            rem_d = rs_q ? -r_nx[DATA_W-1:0] : r_nx[DATA_W-1:0];
          end
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      raw_q   <= '0;
      r_q     <= '0;
      qb_q    <= '0;
      qs_q    <= 1'b0;
      rs_q    <= 1'b0;
      dz_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      raw_q   <= raw_d;
      r_q     <= r_d;
      qb_q    <= qb_d;
      qs_q    <= qs_d;
      rs_q    <= rs_d;
      dz_q    <= dz_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  assign div_busy  = (state_q == CALC) || (state_q == DONE);
  assign div_end   = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_divide.sv
// Directed bench for divide: vector table plus restart and
// mid-operation reset sequences.
module tb_divide;

  logic        clk;
  logic        rst;
  logic        div_begin;
  logic        div_signed;
  logic [31:0] div_op1;
  logic [31:0] div_op2;
  logic        div_busy;
  logic        div_end;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int n_chk;
  int n_fail;

  divide #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .div_begin (div_begin),
    .div_signed(div_signed),
    .div_op1   (div_op1),
    .div_op2   (div_op2),
    .div_busy  (div_busy),
    .div_end   (div_end),
    .quotient  (quotient),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Runs one division; inj injects a 9/3 begin while busy,
  // rst_at pulses reset at that cycle and abandons the op.
  task automatic run_div(input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq,
                         input logic [31:0] er, input string nm,
                         input int inj, input int rst_at);
    int idx;
    int busy_n;
    int ends;
    logic hold_ok;
    logic [31:0] pq;
    logic [31:0] pr;
    pq = quotient;
    pr = remainder;
    hold_ok = 1'b1;
    busy_n = 0;
    @(negedge clk);
    div_begin  = 1'b1;
    div_signed = sgn;
    div_op1    = a;
    div_op2    = b;
    @(posedge clk);
    #1;
    div_begin  = 1'b0;
    div_signed = ~sgn;
    div_op1    = ~a;
    div_op2    = b + 32'd3;
    idx = 1;
    while (!div_end && idx < 100) begin
      if (idx == rst_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk({nm, " rst busy"}, {31'd0, div_busy}, 32'd0);
        chk({nm, " rst end"}, {31'd0, div_end}, 32'd0);
        chk({nm, " rst quo"}, quotient, 32'd0);
        chk({nm, " rst rem"}, remainder, 32'd0);
        ends = 0;
        for (int i = 0; i < 40; i++) begin
          @(posedge clk);
          #1;
          if (div_end || div_busy) ends++;
        end
        chk({nm, " no end after rst"}, 32'(ends), 32'd0);
        return;
      end
      if (div_busy) busy_n++;
      if (quotient !== pq || remainder !== pr) hold_ok = 1'b0;
      if (idx == inj) begin
        div_begin  = 1'b1;
        div_signed = 1'b0;
        div_op1    = 32'd9;
        div_op2    = 32'd3;
      end
      if (idx == inj + 1) div_begin = 1'b0;
      @(posedge clk);
      #1;
      idx++;
    end
    if (div_busy) busy_n++;
    chk({nm, " latency"}, 32'(idx), 32'd33);
    chk({nm, " busy cycles"}, 32'(busy_n), 32'd33);
    chk({nm, " hold"}, {31'd0, hold_ok}, 32'd1);
    chk({nm, " quo"}, quotient, eq);
    chk({nm, " rem"}, remainder, er);
    @(posedge clk);
    #1;
    chk({nm, " end pulse"}, {31'd0, div_end}, 32'd0);
    chk({nm, " idle busy"}, {31'd0, div_busy}, 32'd0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    vecs[0]  = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[2]  = '{1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
    vecs[3]  = '{1'b0, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1};
    vecs[4]  = '{1'b1, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678};
    vecs[5]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
    vecs[6]  = '{1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0};
    vecs[7]  = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF};
    vecs[8]  = '{1'b0, 32'd5, 32'd9, 32'd0, 32'd5};
    vecs[9]  = '{1'b1, 32'h80000000, 32'd2, 32'hC0000000, 32'd0};
    vecs[10] = '{1'b0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd0};

    rst        = 1'b1;
    div_begin  = 1'b0;
    div_signed = 1'b0;
    div_op1    = '0;
    div_op2    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, div_busy}, 32'd0);
    chk("reset end", {31'd0, div_end}, 32'd0);
    chk("reset quo", quotient, 32'd0);
    chk("reset rem", remainder, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
              $sformatf("vec%0d", i), -1, -1);
    end

    run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "restart", 10, -1);
    repeat (5) @(posedge clk);
    #1;
    chk("idle hold quo", quotient, 32'd14);
    chk("idle hold rem", remainder, 32'd2);
    run_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, "after restart", -1, -1);

    run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "midrst", -1, 15);
    run_div(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, "post rst", -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
